// File: rtl/rail_seq_pkg.sv
// rtl/rail_seq_pkg.sv - state encoding and default timing for rail_sequencer
package rail_seq_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_OFF     = 3'd0,
    ST_WAIT_PG = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_ON      = 3'd3,
    ST_DOWN    = 3'd4,
    ST_FAULT   = 3'd5
  } state_t;

  localparam int          DEF_N_RAILS        = 4;
  localparam int          DEF_TIMER_W        = 16;
  localparam int unsigned DEF_PG_TIMEOUT     = 40000;
  localparam int unsigned DEF_SETTLE_CYCLES  = 2000;
  localparam int unsigned DEF_OFF_DELAY      = 2000;
  localparam int unsigned DEF_RETRY_COOLDOWN = 50000;
  localparam int          DEF_MAX_RETRIES    = 3;

endpackage

// File: rtl/rail_sequencer_pg_sync.sv
// rtl/rail_sequencer_pg_sync.sv - parametrised-width 2-flop synchroniser, async active-low reset to 0
module pg_sync #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/rail_sequencer.sv
// rtl/rail_sequencer.sv - ordered power-up/down sequencer for N supply rails with latched fault
// Optional auto-retry from FAULT is built when RAIL_SEQ_RETRY_EN is defined.
module rail_sequencer
  import rail_seq_pkg::*;
#(
  parameter int          N_RAILS        = DEF_N_RAILS,
  parameter int          TIMER_W        = DEF_TIMER_W,
  parameter int unsigned PG_TIMEOUT     = DEF_PG_TIMEOUT,
  parameter int unsigned SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
  parameter int unsigned OFF_DELAY      = DEF_OFF_DELAY,
  parameter int unsigned RETRY_COOLDOWN = DEF_RETRY_COOLDOWN,
  parameter int          MAX_RETRIES    = DEF_MAX_RETRIES
) (
  input  logic                       sysclk,
  input  logic                       reset_INV,
  input  logic                       enable,
  input  logic [N_RAILS-1:0]         pg,
  output logic [N_RAILS-1:0]         en,
  output logic                       all_good,
  output logic                       fault,
  output logic [$clog2(N_RAILS)-1:0] fault_rail,
  output logic [STATE_W-1:0]         state
);

  localparam int                 IDX_W       = $clog2(N_RAILS);
  localparam logic [TIMER_W-1:0] PG_LAST     = TIMER_W'(PG_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] SETTLE_LAST = TIMER_W'(SETTLE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] OFF_LAST    = TIMER_W'(OFF_DELAY - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST    = IDX_W'(N_RAILS - 1);

  state_t               state_q, state_n;
  logic [IDX_W-1:0]     idx_q, idx_n;
  logic [TIMER_W-1:0]   timer_q, timer_n;
  logic [N_RAILS-1:0]   pg_s, sup_mask, fail_mask, en_n;
  logic [IDX_W-1:0]     fault_rail_n, fail_idx;
  logic                 all_good_n, fault_n, down_step, fail_found;

`ifdef RAIL_SEQ_RETRY_EN
  localparam int                 RETRY_W   = $clog2(MAX_RETRIES + 1);
  localparam logic [TIMER_W-1:0] COOL_LAST = TIMER_W'(RETRY_COOLDOWN - 1);
  logic [RETRY_W-1:0] retry_q, retry_n;
`else
  logic unused_retry_cfg;
  assign unused_retry_cfg = ^{RETRY_COOLDOWN, MAX_RETRIES};
`endif

  pg_sync #(.W(N_RAILS)) u_pg_sync (
    .clk   (sysclk),
    .rst_n (reset_INV),
    .d     (pg),
    .q     (pg_s)
  );

  // Rails already past their own WAIT_PG must stay good; the current rail joins once it has settled.
  always_comb begin
    sup_mask = '0;
    for (int i = 0; i < N_RAILS; i++) begin
      if (state_q == ST_WAIT_PG)
        sup_mask[i] = (IDX_W'(i) < idx_q);
      else if (state_q == ST_SETTLE || state_q == ST_ON)
        sup_mask[i] = (IDX_W'(i) <= idx_q);
    end
  end

  assign fail_mask = sup_mask & ~pg_s;

  always_comb begin
    fail_found = |fail_mask;
    fail_idx   = '0;
    for (int i = N_RAILS - 1; i >= 0; i--) begin
      if (fail_mask[i]) fail_idx = IDX_W'(i);
    end
  end

  always_comb begin
    state_n      = state_q;
    idx_n        = idx_q;
    down_step    = 1'b0;
    fault_rail_n = fault_rail;
`ifdef RAIL_SEQ_RETRY_EN
    retry_n      = retry_q;
`endif
    case (state_q)
      ST_OFF: begin
        if (enable) begin
          state_n = ST_WAIT_PG;
          idx_n   = '0;
        end
      end
      ST_WAIT_PG: begin
        if (fail_found) begin
          state_n      = ST_FAULT;
          fault_rail_n = fail_idx;
        end else if (!pg_s[idx_q] && timer_q == PG_LAST) begin
          state_n      = ST_FAULT;
          fault_rail_n = idx_q;
        end else if (!enable) begin
          state_n = ST_DOWN;
        end else if (pg_s[idx_q]) begin
          state_n = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (fail_found) begin
          state_n      = ST_FAULT;
          fault_rail_n = fail_idx;
        end else if (!enable) begin
          state_n = ST_DOWN;
        end else if (timer_q == SETTLE_LAST) begin
          if (idx_q == IDX_LAST) begin
            state_n = ST_ON;
          end else begin
            state_n = ST_WAIT_PG;
            idx_n   = idx_q + IDX_W'(1);
          end
        end
      end
      ST_ON: begin
        if (fail_found) begin
          state_n      = ST_FAULT;
          fault_rail_n = fail_idx;
        end else if (!enable) begin
          state_n = ST_DOWN;
        end
      end
      ST_DOWN: begin
        if (timer_q == OFF_LAST) begin
          if (idx_q != '0) begin
            idx_n     = idx_q - IDX_W'(1);
            down_step = 1'b1;
          end else begin
            state_n = ST_OFF;
          end
        end
      end
      ST_FAULT: begin
        if (!enable) begin
          state_n = ST_OFF;
`ifdef RAIL_SEQ_RETRY_EN
        end else if (timer_q == COOL_LAST && retry_q < RETRY_W'(MAX_RETRIES)) begin
          state_n = ST_WAIT_PG;
          idx_n   = '0;
          retry_n = retry_q + RETRY_W'(1);
`endif
        end
      end
      default: state_n = ST_OFF;
    endcase

    if (state_n != ST_FAULT) fault_rail_n = '0;
`ifdef RAIL_SEQ_RETRY_EN
    if (!enable || state_n == ST_ON) retry_n = '0;
`endif
  end

  // Enables are a pure function of the next state and index, so every rail change lands with the state change.
  always_comb begin
    if (state_n != state_q || down_step)
      timer_n = '0;
    else if (&timer_q)
      timer_n = timer_q;
    else
      timer_n = timer_q + TIMER_W'(1);

    en_n = '0;
    for (int i = 0; i < N_RAILS; i++) begin
      case (state_n)
        ST_WAIT_PG, ST_SETTLE: en_n[i] = (IDX_W'(i) <= idx_n);
        ST_ON:                 en_n[i] = 1'b1;
        ST_DOWN:               en_n[i] = (IDX_W'(i) < idx_n);
        default:               en_n[i] = 1'b0;
      endcase
    end

    all_good_n = (state_q == ST_ON) && (state_n == ST_ON);
    fault_n    = (state_n == ST_FAULT);
  end

  always_ff @(posedge sysclk or negedge reset_INV) begin
    if (!reset_INV) begin
      state_q    <= ST_OFF;
      idx_q      <= '0;
      timer_q    <= '0;
      en         <= '0;
      all_good   <= 1'b0;
      fault      <= 1'b0;
      fault_rail <= '0;
    end else begin
      state_q    <= state_n;
      idx_q      <= idx_n;
      timer_q    <= timer_n;
      en         <= en_n;
      all_good   <= all_good_n;
      fault      <= fault_n;
      fault_rail <= fault_rail_n;
    end
  end

`ifdef RAIL_SEQ_RETRY_EN
  always_ff @(posedge sysclk or negedge reset_INV) begin
    if (!reset_INV) retry_q <= '0;
    else            retry_q <= retry_n;
  end
`endif

  assign state = state_q;

endmodule

// File: tb/tb_rail_sequencer.sv
// tb/tb_rail_sequencer.sv - scoreboard bench for rail_sequencer (N_RAILS=3, short timing)
module tb_rail_sequencer;
  import rail_seq_pkg::*;

  typedef struct packed {
    logic [2:0] en;
    logic       ag;
    logic       f;
    logic [1:0] rail;
    logic [2:0] st;
  } obs_t;

  typedef struct {
    string name;
    int    cyc;
    obs_t  obs;
  } exp_t;

  logic       sysclk = 1'b0;
  logic       reset_INV;
  logic       enable;
  logic [2:0] pg;
  logic [2:0] en;
  logic       all_good;
  logic       fault;
  logic [1:0] fault_rail;
  logic [2:0] state;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  obs_t prev;
  bit   started = 1'b0;

  rail_sequencer #(
    .N_RAILS(3), .TIMER_W(16), .PG_TIMEOUT(100), .SETTLE_CYCLES(10),
    .OFF_DELAY(5), .RETRY_COOLDOWN(30), .MAX_RETRIES(3)
  ) dut (
    .sysclk     (sysclk),
    .reset_INV  (reset_INV),
    .enable     (enable),
    .pg         (pg),
    .en         (en),
    .all_good   (all_good),
    .fault      (fault),
    .fault_rail (fault_rail),
    .state      (state)
  );

  always #5 sysclk = ~sysclk;
  always @(posedge sysclk) cyc <= cyc + 1;

  // Monitor: every change of the observable outputs consumes one expectation.
  always @(negedge sysclk) begin
    obs_t cur;
    exp_t e;
    cur = {en, all_good, fault, fault_rail, state};
    if (!started || cur !== prev) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_change: actual cycle %0d en=%b ag=%b fault=%b rail=%0d state=%0d, required no change",
                 cyc, cur.en, cur.ag, cur.f, cur.rail, cur.st);
      end else begin
        e = q.pop_front();
        if (e.cyc != cyc || e.obs !== cur) begin
          errors++;
          $display("FAIL %s: actual cycle %0d en=%b ag=%b fault=%b rail=%0d state=%0d, required cycle %0d en=%b ag=%b fault=%b rail=%0d state=%0d",
                   e.name, cyc, cur.en, cur.ag, cur.f, cur.rail, cur.st,
                   e.cyc, e.obs.en, e.obs.ag, e.obs.f, e.obs.rail, e.obs.st);
        end
      end
    end
    prev    = cur;
    started = 1'b1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge sysclk);
    #1;
  endtask

  task automatic push_exp(input string name, input int dc, input logic [2:0] e_en, input logic ag,
                          input logic f, input logic [1:0] rail, input logic [2:0] st);
    exp_t x;
    x.name = name;
    x.cyc  = cyc + dc;
    x.obs  = {e_en, ag, f, rail, st};
    q.push_back(x);
  endtask

  // Full power-up from OFF with pg all low; each pg returns 20 cycles after its enable.
  task automatic power_up();
    enable = 1'b1;
    push_exp("up_en0",       1, 3'b001, 0, 0, 0, ST_WAIT_PG);
    push_exp("up_settle0",  24, 3'b001, 0, 0, 0, ST_SETTLE);
    push_exp("up_en1",      34, 3'b011, 0, 0, 0, ST_WAIT_PG);
    push_exp("up_settle1",  57, 3'b011, 0, 0, 0, ST_SETTLE);
    push_exp("up_en2",      67, 3'b111, 0, 0, 0, ST_WAIT_PG);
    push_exp("up_settle2",  90, 3'b111, 0, 0, 0, ST_SETTLE);
    push_exp("up_on",      100, 3'b111, 0, 0, 0, ST_ON);
    push_exp("up_all_good",101, 3'b111, 1, 0, 0, ST_ON);
    tick(21); pg[0] = 1'b1;
    tick(33); pg[1] = 1'b1;
    tick(33); pg[2] = 1'b1;
    tick(16);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_INV = 1'b0;
    enable    = 1'b0;
    pg        = 3'b000;
    push_exp("reset_state", 1, 3'b000, 0, 0, 0, ST_OFF);
    tick(3);
    reset_INV = 1'b1;
    tick(2);

    power_up();

    // Power-down with enable reasserted mid-DOWN, restart, then rail 1 times out.
    enable = 1'b0;
    push_exp("down_en011",     1, 3'b011, 0, 0, 0, ST_DOWN);
    push_exp("down_en001",     6, 3'b001, 0, 0, 0, ST_DOWN);
    push_exp("down_en000",    11, 3'b000, 0, 0, 0, ST_DOWN);
    push_exp("down_off",      16, 3'b000, 0, 0, 0, ST_OFF);
    push_exp("restart_en0",   17, 3'b001, 0, 0, 0, ST_WAIT_PG);
    push_exp("restart_settle",40, 3'b001, 0, 0, 0, ST_SETTLE);
    push_exp("restart_en1",   50, 3'b011, 0, 0, 0, ST_WAIT_PG);
    push_exp("timeout_rail1",150, 3'b000, 0, 1, 1, ST_FAULT);
    push_exp("timeout_clear",153, 3'b000, 0, 0, 0, ST_OFF);
    tick(2);   pg[2]  = 1'b0;
    tick(1);   enable = 1'b1;
    tick(4);   pg[1]  = 1'b0;
    tick(5);   pg[0]  = 1'b0;
    tick(25);  pg[0]  = 1'b1;
    tick(115); enable = 1'b0;
    tick(3);   pg     = 3'b000;
    tick(4);

    // Brown-out of rails 0 and 2 while ON.
    power_up();
    pg[0] = 1'b0;
    pg[2] = 1'b0;
    push_exp("brownout_fault", 3, 3'b000, 0, 1, 0, ST_FAULT);
    push_exp("brownout_clear", 6, 3'b000, 0, 0, 0, ST_OFF);
    tick(5); enable = 1'b0;
    pg = 3'b000;
    tick(4);

    // Asynchronous reset while rail 1 is settling, then restart.
    enable = 1'b1;
    push_exp("rst_up_en0",      1, 3'b001, 0, 0, 0, ST_WAIT_PG);
    push_exp("rst_up_settle0", 24, 3'b001, 0, 0, 0, ST_SETTLE);
    push_exp("rst_up_en1",     34, 3'b011, 0, 0, 0, ST_WAIT_PG);
    push_exp("rst_up_settle1", 57, 3'b011, 0, 0, 0, ST_SETTLE);
    tick(21); pg[0] = 1'b1;
    tick(33); pg[1] = 1'b1;
    tick(6);
    reset_INV = 1'b0;
    pg = 3'b000;
    push_exp("async_reset", 0, 3'b000, 0, 0, 0, ST_OFF);
    tick(3);
    reset_INV = 1'b1;
    push_exp("rst_restart", 1, 3'b001, 0, 0, 0, ST_WAIT_PG);
    tick(3);
    enable = 1'b0;
    push_exp("rst_down", 1, 3'b000, 0, 0, 0, ST_DOWN);
    push_exp("rst_off",  6, 3'b000, 0, 0, 0, ST_OFF);
    tick(8);

`ifdef RAIL_SEQ_RETRY_EN
    // Rail 2 never reports good: three retries spaced by the cooldown, then FAULT holds.
    pg = 3'b011;
    tick(4);
    enable = 1'b1;
    for (int k = 0; k < 4; k++) begin
      int w;
      w = 1 + 152 * k;
      push_exp("retry_en0",     w,       3'b001, 0, 0, 0, ST_WAIT_PG);
      push_exp("retry_settle0", w + 1,   3'b001, 0, 0, 0, ST_SETTLE);
      push_exp("retry_en1",     w + 11,  3'b011, 0, 0, 0, ST_WAIT_PG);
      push_exp("retry_settle1", w + 12,  3'b011, 0, 0, 0, ST_SETTLE);
      push_exp("retry_en2",     w + 22,  3'b111, 0, 0, 0, ST_WAIT_PG);
      push_exp("retry_timeout", w + 122, 3'b000, 0, 1, 2, ST_FAULT);
    end
    tick(639);
    enable = 1'b0;
    push_exp("retry_clear", 1, 3'b000, 0, 0, 0, ST_OFF);
    tick(3);
    pg = 3'b000;
    tick(2);
`endif

    tick(3);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL pending_expectations: actual %0d outstanding (next %s at cycle %0d), required 0",
               q.size(), q[0].name, q[0].cyc);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rail_sequencer.md
Name: rail_sequencer

Overview:
Parametrised power-rail sequencer for N supply rails.
- Enables rails in ascending index order, waiting for each power-good plus a settle delay before enabling the next.
- Disables rails in descending order with a per-step off-delay.
- Any timeout or loss of power-good drops all rails at once and latches a fault.
- Sits between the board top level and the regulator enable/PG pins; successor to the fixed-rail DSP power sequencer.

Parameters:
N_RAILS, 4, number of sequenced rails (2..16)
TIMER_W, 16, width of the step timer
PG_TIMEOUT, 16'd40000, sysclk cycles allowed for pg[idx] to assert after en[idx]
SETTLE_CYCLES, 16'd2000, cycles to wait after pg[idx] before the next rail
OFF_DELAY, 16'd2000, cycles between successive rail disables
RETRY_COOLDOWN, 16'd50000, cycles in FAULT before auto-retry (RETRY_EN only)
MAX_RETRIES, 3, auto-retry attempts (RETRY_EN only)

Ports:
sysclk  in  1  sequencer clock (internal oscillator domain)
reset_INV  in  1  asynchronous active-low reset
enable  in  1  level request: 1 = power up, 0 = power down
pg  in  N_RAILS  raw power-good inputs, asynchronous
en  out  N_RAILS  rail enables
all_good  out  1  all rails up and settled
fault  out  1  latched fault
fault_rail  out  $clog2(N_RAILS)  index of the failing rail
state  out  3  current FSM state, for LEDs/debug

Interface fixed facts: one clock, sysclk. Reset is reset_INV, asynchronous assert, active-low.

Behaviour:
- Reset values: en=0, all_good=0, fault=0, fault_rail=0, state=OFF, idx=0, timer=0.
- pg passes through a 2-flop synchroniser; pg_s lags pg by 2 cycles. All decisions use pg_s.
- The timer clears on every state transition and increments saturating at all-ones.
- States:
  - OFF(0)
  - WAIT_PG(1)
  - SETTLE(2)
  - ON(3)
  - DOWN(4)
  - FAULT(5)
- OFF:
  - en=0.
  - enable=1 → WAIT_PG with idx=0.
- WAIT_PG:
  - en[i]=1 for all i≤idx.
  - pg_s[idx]=1 → SETTLE.
  - timer==PG_TIMEOUT-1 without pg_s[idx] → FAULT, fault_rail=idx.
- SETTLE:
  - timer==SETTLE_CYCLES-1 and idx<N_RAILS-1 → idx+1, WAIT_PG.
  - timer==SETTLE_CYCLES-1 and idx==N_RAILS-1 → ON.
- ON:
  - all_good=1 (registered; asserts the cycle after entry).
  - en is all ones.
- Supervision (WAIT_PG, SETTLE, ON): any pg_s[i]=0 for i<idx (or i≤idx once in SETTLE/ON) → FAULT.
  - fault_rail = lowest failing index.
  - Supervision has priority over the timer/advance checks in the same cycle.
- enable=0 in WAIT_PG, SETTLE or ON → DOWN.
  - Keep the current idx.
  - Clear en[idx] immediately.
- DOWN:
  - At timer==OFF_DELAY-1: if idx>0 → idx-1, clear en[idx-1], timer restart; if idx==0 → OFF.
  - pg is ignored in DOWN.
  - enable reasserting mid-DOWN does not abort: the full power-down completes to OFF, then OFF sees enable=1 and restarts from rail 0.
- FAULT:
  - en=0 on all rails in the same cycle as entry (registered outputs: first cycle after detection).
  - fault=1 and fault_rail are held.
  - enable=0 → OFF; fault and fault_rail clear on exit.
- enable and fault detection in the same cycle: FAULT wins.
- Async reset mid-sequence: all en drop immediately (async clear of the en registers).

Optional Feature:
RAIL_SEQ_RETRY_EN
- Defined:
  - In FAULT with enable=1, after RETRY_COOLDOWN cycles and retry_cnt<MAX_RETRIES: retry_cnt+1, clear fault, → WAIT_PG idx=0.
  - retry_cnt clears on reaching ON or on enable=0.
  - Once the limit is reached, FAULT holds until enable=0.
- Undefined: FAULT holds until enable=0; no retry counter is synthesised.

Decomposition:
- Package rail_seq_pkg holds:
  - state encoding constants ST_OFF..ST_FAULT (3-bit);
  - state width constant;
  - default timing constants.
- One sub-module, pg_sync: parametrised-width 2-flop synchroniser with async active-low reset to 0.

Test Plan:
Bench values: N_RAILS=3, PG_TIMEOUT=100, SETTLE_CYCLES=10, OFF_DELAY=5.
1. Normal power-up: enable=1, each pg returns 20 cycles after its en → en goes 001, 011, 111; all_good=1 at ≈3×(20+2+10)+small cycles; state=3.
2. Timeout: pg[1] never asserts → fault=1, fault_rail=1, en=000 exactly 100 cycles after en[1] rises; state=5.
3. Brown-out: in ON, drop pg[0] and pg[2] together → FAULT, fault_rail=0, en=000 within 3 cycles.
4. Power-down with re-enable: ON, enable=0 → en 011 immediately, 001 after 5 cycles, 000 after 10; enable=1 pulsed at cycle 3 → sequence finishes to OFF, then restarts from rail 0.
5. Reset mid-SETTLE of rail 1: reset_INV=0 → en=000 asynchronously, fault=0; release → OFF, then restarts if enable=1.
6. (RAIL_SEQ_RETRY_EN) persistent timeout on rail 2 → exactly 3 retries spaced by cooldown; then fault stays 1; enable=0 clears it.
